// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences an asynchronous SRAM and shares it between two
// req/ack requesters. Each access is SETUP -> ACCESS (WAIT_CYCLES) -> DONE,
// with active-low strobes and in-chip tristate control via dat_out/dat_oe.
// All outputs are registered from the next-state decode.
// Optional build macro: SRAM_RR_ARB_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ADR,
    output logic [DATA_W-1:0] dat_out,
    output logic              dat_oe,
    input  logic [DATA_W-1:0] dat_in,
    output logic              RAMCS,
    output logic              RAMOE,
    output logic              RAMWE
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    // The down-counter is 4 bits wide, which covers WAIT_CYCLES up to 15.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              acc_gnt, acc_gnt_nx;
    logic              acc_we, acc_we_nx;
    logic [ADDR_W-1:0] acc_addr, acc_addr_nx;
    logic [DATA_W-1:0] acc_wdata, acc_wdata_nx;

    logic              cs_nx, oe_nx, wen_nx, doe_nx, ack0_nx, ack1_nx;
    logic [ADDR_W-1:0] adr_nx;
    logic [DATA_W-1:0] dout_nx, rdata_nx;

`ifdef SRAM_RR_ARB_EN
    // prio names the requester that wins the next simultaneous request.
    logic prio, prio_nx;
`endif

    // Next-state logic: arbitrate and latch the winning request in IDLE, then
    // walk through the fixed access sequence ignoring further requests.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        acc_gnt_nx   = acc_gnt;
        acc_we_nx    = acc_we;
        acc_addr_nx  = acc_addr;
        acc_wdata_nx = acc_wdata;
`ifdef SRAM_RR_ARB_EN
        prio_nx      = prio;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
`ifdef SRAM_RR_ARB_EN
                    if (req0 && req1) begin
                        acc_gnt_nx = prio;
                    end else begin
                        acc_gnt_nx = req1;
                    end
                    prio_nx = ~acc_gnt_nx;
`else
                    acc_gnt_nx = ~req0;
`endif
                    acc_we_nx    = acc_gnt_nx ? we1    : we0;
                    acc_addr_nx  = acc_gnt_nx ? addr1  : addr0;
                    acc_wdata_nx = acc_gnt_nx ? wdata1 : wdata0;
                    state_nx     = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
                cnt_nx   = CNT_INIT;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every pin comes straight off a
    // flop; address and write data are held between accesses.
    always_comb begin
        cs_nx    = 1'b1;
        oe_nx    = 1'b1;
        wen_nx   = 1'b1;
        doe_nx   = 1'b0;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        adr_nx   = ADR;
        dout_nx  = dat_out;
        rdata_nx = rdata;
        case (state_nx)
            SETUP: begin
                cs_nx  = 1'b0;
                adr_nx = acc_addr_nx;
                doe_nx = acc_we_nx;
                if (acc_we_nx) begin
                    dout_nx = acc_wdata_nx;
                end
            end
            ACCESS: begin
                cs_nx  = 1'b0;
                doe_nx = acc_we;
                if (acc_we) begin
                    wen_nx = 1'b0;
                end else begin
                    oe_nx = 1'b0;
                end
            end
            DONE: begin
                cs_nx   = 1'b0;
                doe_nx  = acc_we;
                ack0_nx = ~acc_gnt;
                ack1_nx = acc_gnt;
            end
            default: begin
            end
        endcase
        if (state == ACCESS && cnt == 4'd0 && !acc_we) begin
            rdata_nx = dat_in;
        end
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            acc_gnt   <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            acc_gnt   <= acc_gnt_nx;
            acc_we    <= acc_we_nx;
            acc_addr  <= acc_addr_nx;
            acc_wdata <= acc_wdata_nx;
        end
    end

`ifdef SRAM_RR_ARB_EN
    // Round-robin pointer, starting with requester 0 favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else begin
            prio <= prio_nx;
        end
    end
`endif

    // Registered SRAM strobes, handshake and data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            RAMCS   <= 1'b1;
            RAMOE   <= 1'b1;
            RAMWE   <= 1'b1;
            dat_oe  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            ADR     <= '0;
            dat_out <= '0;
            rdata   <= '0;
        end else begin
            RAMCS   <= cs_nx;
            RAMOE   <= oe_nx;
            RAMWE   <= wen_nx;
            dat_oe  <= doe_nx;
            ack0    <= ack0_nx;
            ack1    <= ack1_nx;
            ADR     <= adr_nx;
            dat_out <= dout_nx;
            rdata   <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter. A main instance with
// WAIT_CYCLES = 2 is exercised by a vector table, hand-written corner
// sequences and a randomized run against a transaction-level model; two
// extra instances (WAIT_CYCLES = 1 and 15) share its inputs for latency.
module tb_sram_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [18:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata, dat_out, dat_in;
    logic [18:0] ADR;
    logic        dat_oe, RAMCS, RAMOE, RAMWE;

    logic        a1_ack0, a1_ack1, a1_doe, a1_cs, a1_oe, a1_we;
    logic [15:0] a1_rdata, a1_dout;
    logic [18:0] a1_adr;
    logic        a15_ack0, a15_ack1, a15_doe, a15_cs, a15_oe, a15_we;
    logic [15:0] a15_rdata, a15_dout;
    logic [18:0] a15_adr;
    logic [15:0] aux_din = 16'h1234;

    typedef struct {
        int          who;
        bit          we;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    int          checks, errors, cyc;
    logic [15:0] ref_mem [32];
    logic [15:0] sram [32];

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .ADR(ADR), .dat_out(dat_out), .dat_oe(dat_oe),
        .dat_in(dat_in), .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(a1_ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(a1_ack1),
        .rdata(a1_rdata), .ADR(a1_adr), .dat_out(a1_dout), .dat_oe(a1_doe),
        .dat_in(aux_din), .RAMCS(a1_cs), .RAMOE(a1_oe), .RAMWE(a1_we)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(a15_ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(a15_ack1),
        .rdata(a15_rdata), .ADR(a15_adr), .dat_out(a15_dout), .dat_oe(a15_doe),
        .dat_in(aux_din), .RAMCS(a15_cs), .RAMOE(a15_oe), .RAMWE(a15_we)
    );

    function automatic logic [4:0] mem_idx(input logic [18:0] a);
        return {a[18], a[3:0]};
    endfunction

    function automatic logic [15:0] init_val(input int i);
        return 16'hA5A5 ^ 16'(i * 291);
    endfunction

    // Asynchronous SRAM model: stores while CS and WE are low.
    initial begin
        for (int i = 0; i < 32; i++) sram[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!RAMCS && !RAMWE) sram[mem_idx(ADR)] = dat_out;
        end
    end

    // SRAM read path: drives stored data while CS and OE are low.
    always_comb begin
        dat_in = 16'h5A5A;
        if (!RAMCS && !RAMOE) dat_in = sram[mem_idx(ADR)];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        checkOutput("oe_we_main", 32'(!RAMOE && !RAMWE), 0);
        checkOutput("oe_we_w1", 32'(!a1_oe && !a1_we), 0);
        checkOutput("oe_we_w15", 32'(!a15_oe && !a15_we), 0);
        checkOutput("ack_excl", 32'(ack0 && ack1), 0);
        checkOutput("doe_on_read", 32'((dat_oe && !RAMOE) || (a1_doe && !a1_oe) || (a15_doe && !a15_oe)), 0);
    endtask

    task automatic dropReqs();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic doReset();
        dropReqs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.who == 0) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        if (v.we) ref_mem[mem_idx(v.addr)] = v.wdata;
    endtask

    task automatic observeAccess(input vec_t v, input int id);
        int cs_n = 0, we_n = 0, oe_n = 0, doe_n = 0, ack_k = -1;
        int bad_adr = 0, bad_dout = 0, other_ack = 0;
        logic [15:0] rd_at_ack = 16'h0;
        for (int k = 1; k <= W + 3; k++) begin
            step();
            if (!RAMCS) begin
                cs_n++;
                if (ADR !== v.addr) bad_adr++;
            end
            if (!RAMWE) we_n++;
            if (!RAMOE) oe_n++;
            if (dat_oe) begin
                doe_n++;
                if (dat_out !== v.wdata) bad_dout++;
            end
            if (((v.who == 0) ? ack0 : ack1) === 1'b1) begin
                if (ack_k < 0) ack_k = k;
                rd_at_ack = rdata;
                dropReqs();
            end
            if (((v.who == 0) ? ack1 : ack0) === 1'b1) other_ack++;
            if (k == W + 3) begin
                checkOutput($sformatf("v%0d_cs_release", id), 32'(RAMCS), 1);
                checkOutput($sformatf("v%0d_doe_release", id), 32'(dat_oe), 0);
            end
        end
        dropReqs();
        checkOutput($sformatf("v%0d_ack_latency", id), 32'(ack_k), W + 2);
        checkOutput($sformatf("v%0d_cs_width", id), 32'(cs_n), W + 2);
        checkOutput($sformatf("v%0d_we_width", id), 32'(we_n), v.we ? W : 0);
        checkOutput($sformatf("v%0d_oe_width", id), 32'(oe_n), v.we ? 0 : W);
        checkOutput($sformatf("v%0d_doe_width", id), 32'(doe_n), v.we ? W + 2 : 0);
        checkOutput($sformatf("v%0d_adr", id), 32'(bad_adr), 0);
        checkOutput($sformatf("v%0d_dout", id), 32'(bad_dout), 0);
        checkOutput($sformatf("v%0d_other_ack", id), 32'(other_ack), 0);
        if (!v.we) checkOutput($sformatf("v%0d_rdata", id), 32'(rd_at_ack), 32'(v.exp_rdata));
        step();
        step();
    endtask

    initial begin
        vec_t        vecs [7];
        vec_t        post;
        int          order [4];
        int          exp_order [4];
        int          n, ack_seen;
        int          m_ack, a1_ack, a15_ack, m_oe, a1_oe_n, a15_oe_n, aux_bad;
        bit          act [2];
        bit          t_we [2];
        logic [18:0] t_addr [2];
        logic [15:0] t_wdata [2];
        int          remaining [2];
        bit          busy, m_we;
        int          owner, ack_at, idle_from, last_grant, g;
        logic [15:0] exp_rd;

        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

        vecs[0] = '{0, 1'b1, 19'h00012, 16'hBEEF, 16'h0000};
        vecs[1] = '{1, 1'b0, 19'h00012, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1'b1, 19'h7FFF3, 16'h1234, 16'h0000};
        vecs[3] = '{0, 1'b0, 19'h7FFF3, 16'h0000, 16'h1234};
        vecs[4] = '{0, 1'b0, 19'h00003, 16'h0000, init_val(3)};
        vecs[5] = '{1, 1'b1, 19'h00012, 16'h0F0F, 16'h0000};
        vecs[6] = '{0, 1'b0, 19'h00012, 16'h0000, 16'h0F0F};

        repeat (3) step();
        checkOutput("rst_cs", 32'(RAMCS), 1);
        checkOutput("rst_oe", 32'(RAMOE), 1);
        checkOutput("rst_we", 32'(RAMWE), 1);
        checkOutput("rst_doe", 32'(dat_oe), 0);
        checkOutput("rst_ack", 32'({ack0, ack1}), 0);
        checkOutput("rst_adr", 32'(ADR), 0);
        checkOutput("rst_dout", 32'(dat_out), 0);
        checkOutput("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        step();

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            observeAccess(vecs[i], i);
        end

        $display("[TB] reset during write access");
        req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00009; wdata0 = 16'hCAFE;
        step();
        checkOutput("abort_setup_cs", 32'(RAMCS), 0);
        step();
        checkOutput("abort_in_access", 32'(RAMWE), 0);
        rst = 1'b1;
        req0 = 1'b0;
        step();
        checkOutput("abort_cs", 32'(RAMCS), 1);
        checkOutput("abort_we", 32'(RAMWE), 1);
        checkOutput("abort_doe", 32'(dat_oe), 0);
        checkOutput("abort_ack", 32'({ack0, ack1}), 0);
        checkOutput("abort_rdata", 32'(rdata), 0);
        rst = 1'b0;
        ack_seen = 0;
        repeat (W + 4) begin
            step();
            if (ack0 || ack1 || !RAMCS) ack_seen++;
        end
        checkOutput("abort_quiet", 32'(ack_seen), 0);
        post = '{0, 1'b0, 19'h00001, 16'h0000, ref_mem[1]};
        applyStimulus(post);
        observeAccess(post, 100);

        $display("[TB] simultaneous requests");
        doReset();
`ifdef SRAM_RR_ARB_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        order = '{-1, -1, -1, -1};
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h00001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 19'h00002;
        n = 0;
        for (int k = 0; k < 80 && n < 4; k++) begin
            step();
            if (ack0 || ack1) begin
                order[n] = ack1 ? 1 : 0;
                checkOutput($sformatf("arb_rdata%0d", n), 32'(rdata),
                            32'(ref_mem[mem_idx(ack1 ? addr1 : addr0)]));
                n++;
                if (n == 4) dropReqs();
            end
        end
        dropReqs();
        checkOutput("arb_count", 32'(n), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("arb_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
        step();
        step();

        $display("[TB] latency for WAIT_CYCLES 1, 2, 15");
        doReset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h0000A;
        m_ack = -1; a1_ack = -1; a15_ack = -1;
        m_oe = 0; a1_oe_n = 0; a15_oe_n = 0; aux_bad = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) req0 = 1'b0;
            if (!RAMOE) m_oe++;
            if (!a1_oe) a1_oe_n++;
            if (!a15_oe) a15_oe_n++;
            if (!a1_cs && a1_adr !== 19'h0000A) aux_bad++;
            if (!a15_cs && a15_adr !== 19'h0000A) aux_bad++;
            if (ack0 && m_ack < 0) begin
                m_ack = k;
                checkOutput("lat_main_rdata", 32'(rdata), 32'(ref_mem[10]));
            end
            if (a1_ack0 && a1_ack < 0) begin
                a1_ack = k;
                checkOutput("lat_w1_rdata", 32'(a1_rdata), 32'h1234);
            end
            if (a15_ack0 && a15_ack < 0) begin
                a15_ack = k;
                checkOutput("lat_w15_rdata", 32'(a15_rdata), 32'h1234);
            end
            if (a1_ack1 || a15_ack1) aux_bad++;
        end
        checkOutput("lat_main_ack", 32'(m_ack), W + 2);
        checkOutput("lat_w1_ack", 32'(a1_ack), 3);
        checkOutput("lat_w15_ack", 32'(a15_ack), 17);
        checkOutput("lat_main_oe", 32'(m_oe), W);
        checkOutput("lat_w1_oe", 32'(a1_oe_n), 1);
        checkOutput("lat_w15_oe", 32'(a15_oe_n), 15);
        checkOutput("lat_aux_misc", 32'(aux_bad), 0);
        checkOutput("lat_aux_dout", 32'({a1_dout, a15_dout}), 0);

        $display("[TB] randomized traffic");
        doReset();
        busy = 1'b0; m_we = 1'b0; owner = 0; ack_at = 0; exp_rd = '0;
        idle_from = cyc;
        last_grant = 1;
        remaining[0] = 25; remaining[1] = 25;
        act[0] = 1'b0; act[1] = 1'b0;
        for (int k = 0; k < 4000 && (remaining[0] + remaining[1] + int'(act[0]) + int'(act[1]) > 0 || busy); k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && remaining[i] > 0 && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    remaining[i]--;
                    t_we[i] = 1'($urandom_range(0, 1));
                    t_addr[i] = ($urandom_range(0, 1) == 1) ? 19'h7FFF0 + 19'($urandom_range(0, 3))
                                                             : 19'($urandom_range(0, 3));
                    t_wdata[i] = 16'($urandom);
                end
            end
            req0 = act[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wdata[0];
            req1 = act[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wdata[1];
            if (!busy && cyc >= idle_from && (act[0] || act[1])) begin
`ifdef SRAM_RR_ARB_EN
                g = (act[0] && act[1]) ? 1 - last_grant : (act[1] ? 1 : 0);
`else
                g = act[0] ? 0 : 1;
`endif
                busy = 1'b1;
                owner = g;
                last_grant = g;
                ack_at = cyc + 2 + W;
                m_we = t_we[g];
                if (m_we) ref_mem[mem_idx(t_addr[g])] = t_wdata[g];
                else exp_rd = ref_mem[mem_idx(t_addr[g])];
            end
            step();
            checkOutput("rnd_ack0", 32'(ack0), 32'(busy && cyc == ack_at && owner == 0));
            checkOutput("rnd_ack1", 32'(ack1), 32'(busy && cyc == ack_at && owner == 1));
            if (busy && cyc == ack_at) begin
                if (!m_we) checkOutput("rnd_rdata", 32'(rdata), 32'(exp_rd));
                busy = 1'b0;
                idle_from = cyc + 1;
            end
            if (ack0) act[0] = 1'b0;
            if (ack1) act[1] = 1'b0;
        end
        checkOutput("rnd_complete", 32'(remaining[0] + remaining[1] + int'(act[0]) + int'(act[1])), 0);
        dropReqs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the board's asynchronous SRAM (ADR/DAT/RAMOE/RAMWE/RAMCS) and shares it between two requesters, e.g. the lock FSM and a debug/logger port.
- Each requester uses a simple req/ack handshake for single 16-bit read or write accesses.
- The block generates active-low SRAM strobes with a programmable access width.
- Tristating of DAT is done in chip from dat_out/dat_oe.

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, number of clk cycles the OE or WE strobe stays asserted; legal range is 1..15.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous reset, active-high.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0 write (1) / read (0); sampled with req0.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same as requester 0, for requester 1.
- rdata  output  DATA_W  read data; valid in the ack cycle and held until the next read completes.
- ADR  output  ADDR_W  SRAM address.
- dat_out  output  DATA_W  SRAM write data.
- dat_oe  output  1  1 = drive DAT with dat_out.
- dat_in  input  DATA_W  SRAM data pins read back.
- RAMCS  output  1  chip select, active-low.
- RAMOE  output  1  output enable, active-low.
- RAMWE  output  1  write enable, active-low.

Behaviour:
- Reset, and every cycle rst is high:
  - state = IDLE.
  - RAMCS = RAMOE = RAMWE = 1, dat_oe = 0.
  - ack0 = ack1 = 0, ADR = 0, dat_out = 0, rdata = 0.
  - Priority pointer = requester 0.
  - Reset mid-access aborts immediately; no ack is issued.
- All outputs are registered.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples req0/req1.
  - If any request is present, it grants one, latches that requester's we/addr/wdata into internal registers, and goes to SETUP.
  - Requests are ignored in every state other than IDLE.
- SETUP (1 cycle):
  - RAMCS = 0, ADR = latched address.
  - Write: dat_oe = 1, dat_out = wdata, RAMWE = 1.
  - Read: dat_oe = 0, RAMOE = 1.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - Write: RAMWE = 0.
  - Read: RAMOE = 0.
  - rdata captures dat_in on the last ACCESS cycle, reads only.
- DONE (1 cycle):
  - RAMWE = RAMOE = 1; RAMCS stays 0.
  - For writes, dat_oe and ADR stay asserted, giving one cycle of data/address hold.
  - Granted ack pulses high for this cycle only.
- Leaving DONE: RAMCS = 1, dat_oe = 0.
- Latency: request seen in IDLE at cycle N -> ack at cycle N+2+WAIT_CYCLES; IDLE again at N+3+WAIT_CYCLES.
- Back-to-back requests: a requester still holding req in IDLE after its ack starts a new access. Requesters must drop req in the ack cycle if no further access is wanted.
- RAMOE and RAMWE are never both 0. dat_oe = 1 only during write SETUP/ACCESS/DONE.
- ack0 and ack1 are never both high.

Optional Feature:
- SRAM_RR_ARB_EN defined: round-robin arbitration.
  - When both requesters are pending in IDLE, the one not granted last wins.
  - The pointer updates on each grant.
  - A lone request is granted immediately.
- Not defined: fixed priority; requester 0 always wins a simultaneous request, and the pointer logic is removed.

Test Plan:
- Write, WAIT_CYCLES = 2: rst, then req0 = 1, we0 = 1, addr0 = 0x00012, wdata0 = 0xBEEF.
  - Required: RAMCS low for 4 cycles, RAMWE low for exactly 2, dat_oe high for 4.
  - ADR = 0x00012, dat_out = 0xBEEF; ack0 pulses at N+4.
- Read: req1, we1 = 0, addr1 = 0x00012, SRAM model returns 0xBEEF.
  - Required: RAMOE low 2 cycles, RAMWE high throughout, dat_oe = 0.
  - ack1 at N+4 with rdata = 0xBEEF.
- Simultaneous req0 = req1 = 1 held for 4 accesses.
  - With SRAM_RR_ARB_EN: grant order 0, 1, 0, 1.
  - Without it: 0, 0, 0, 0 while req0 is held.
- Assert rst during the ACCESS cycle of a write.
  - Required: next cycle RAMCS = RAMWE = 1, dat_oe = 0, no ack.
  - A subsequent request completes normally.
- WAIT_CYCLES = 1 and WAIT_CYCLES = 15: ack at N+3 and N+17 respectively.
  - Strobe width equals WAIT_CYCLES.
  - RAMOE and RAMWE are never both low.
